// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- iterative restoring divider for DIV / DIVU, sitting next to ex.
//
// The ex stage presents the operands together with i_start and stalls until
// o_ready is seen.  One quotient bit is produced per clock, so a normal divide
// completes DATA_W+1 edges after the start is sampled.  A zero divisor is
// detected when the request is accepted and finishes after 2 edges with a
// zero result.  The result is {remainder, quotient}, which ex writes to HI/LO.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous reset, active low
//   i_signed_div   1 = signed DIV, 0 = DIVU (sampled with i_start)
//   i_opdata_0     dividend (sampled with i_start)
//   i_opdata_1     divisor  (sampled with i_start)
//   i_start        request, held high by ex until it sees o_ready
//   i_annul        abort any in-flight division (flush / exception)
//   o_result       {remainder, quotient}; valid only while o_ready = 1
//   o_ready        result valid (registered)
//   o_div_by_zero  only with `DIV_ZERO_FLAG_EN: raised with o_ready when the
//                  latched divisor was zero, cleared on return to FREE
//
// Configuration macro: DIV_ZERO_FLAG_EN
// -----------------------------------------------------------------------------
module div #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_signed_div,
  input  logic [DATA_W-1:0]     i_opdata_0,
  input  logic [DATA_W-1:0]     i_opdata_1,
  input  logic                  i_start,
  input  logic                  i_annul,
  output logic [2*DATA_W-1:0]   o_result,
  output logic                  o_ready
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                  o_div_by_zero
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BY_ZERO,
    ST_ON,
    ST_END
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rem_q;      // partial remainder
  logic [DATA_W-1:0]  quo_q;      // dividend shifts out as quotient shifts in
  logic [DATA_W-1:0]  dvs_q;      // divisor magnitude
  logic               neg_quo_q;  // operand signs differed
  logic               neg_rem_q;  // dividend was negative

  // ---------------------------------------------------------------------------
  // Operand conditioning: signed mode works on magnitudes.  The magnitude of
  // the most negative value is itself, which as an unsigned number is correct.
  // ---------------------------------------------------------------------------
  logic               a_neg, b_neg;
  logic [DATA_W-1:0]  a_mag, b_mag;
  logic               accept;

  assign a_neg  = i_signed_div & i_opdata_0[DATA_W-1];
  assign b_neg  = i_signed_div & i_opdata_1[DATA_W-1];
  assign a_mag  = a_neg ? -i_opdata_0 : i_opdata_0;
  assign b_mag  = b_neg ? -i_opdata_1 : i_opdata_1;
  // A simultaneous annul suppresses the start.
  assign accept = i_start & ~i_annul;

  // ---------------------------------------------------------------------------
  // One restoring step: shift {rem,quo} left, trial-subtract the divisor and
  // keep the difference only when it did not borrow.  rem < divisor holds
  // before each step, so the kept difference always fits in DATA_W bits.
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]    trial, diff;
  logic               borrow;
  logic [DATA_W-1:0]  rem_step, quo_step, rem_fix, quo_fix;
  logic               last_step;

  assign trial     = {rem_q, quo_q[DATA_W-1]};
  assign diff      = trial - {1'b0, dvs_q};
  assign borrow    = diff[DATA_W];
  assign rem_step  = borrow ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_step  = {quo_q[DATA_W-2:0], ~borrow};
  // Sign correction, modulo 2^DATA_W (0x80000000 / -1 wraps, no trap).
  assign quo_fix   = neg_quo_q ? -quo_step : quo_step;
  assign rem_fix   = neg_rem_q ? -rem_step : rem_step;
  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_FREE;
    else          state_q <= state_d;
  end

  // NOTE: the default assignment first guarantees state_d is written on every
  // path, so no latch is inferred for the states that do not change it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FREE:    if (accept) state_d = (i_opdata_1 == '0) ? ST_BY_ZERO : ST_ON;
      ST_BY_ZERO: state_d = ST_END;
      ST_ON: begin
        if (i_annul)        state_d = ST_FREE;
        else if (last_step) state_d = ST_END;
      end
      ST_END:     if (!i_start || i_annul) state_d = ST_FREE;
      default:    state_d = ST_FREE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      o_ready       <= 1'b0;
      o_result      <= '0;
`ifdef DIV_ZERO_FLAG_EN
      o_div_by_zero <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_FREE: begin
          o_ready  <= 1'b0;
          o_result <= '0;
          if (accept && (i_opdata_1 != '0)) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
          end
        end

        ST_BY_ZERO: begin
          o_ready       <= 1'b1;
          o_result      <= '0;
`ifdef DIV_ZERO_FLAG_EN
          o_div_by_zero <= 1'b1;
`endif
        end

        ST_ON: begin
          // On annul nothing is updated: o_ready stays low and the partial
          // result is simply abandoned.
          if (!i_annul) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
              o_ready  <= 1'b1;
              o_result <= {rem_fix, quo_fix};
            end
          end
        end

        ST_END: begin
          if (!i_start || i_annul) begin
            o_ready       <= 1'b0;
            o_result      <= '0;
`ifdef DIV_ZERO_FLAG_EN
            o_div_by_zero <= 1'b0;
`endif
          end
        end

        default: begin
          o_ready  <= 1'b0;
          o_result <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- directed self-checking bench for the iterative divider.
// Expected results below are computed by hand from the divider's definition.
// -----------------------------------------------------------------------------
module tb_div;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_signed_div;
  logic [31:0] i_opdata_0;
  logic [31:0] i_opdata_1;
  logic        i_start;
  logic        i_annul;
  logic [63:0] o_result;
  logic        o_ready;
`ifdef DIV_ZERO_FLAG_EN
  logic        o_div_by_zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  div #(.DATA_W(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_signed_div (i_signed_div),
    .i_opdata_0   (i_opdata_0),
    .i_opdata_1   (i_opdata_1),
    .i_start      (i_start),
    .i_annul      (i_annul),
    .o_result     (o_result),
    .o_ready      (o_ready)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .o_div_by_zero(o_div_by_zero)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Full transaction: start, wait for o_ready (bounded), check latency and
  // result, drop start, check the return to idle.  Operands are scrambled
  // after the accepting edge to show they were latched.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int edges;
    edges = 0;
    @(negedge i_clk);
    i_signed_div = sgn;
    i_opdata_0   = a;
    i_opdata_1   = b;
    i_start      = 1'b1;
    while (edges < 40) begin
      @(posedge i_clk);
      edges++;
      #1;
      if (edges == 1) begin
        i_opdata_0   = 32'h1234_5678;
        i_opdata_1   = 32'h0000_0003;
        i_signed_div = ~sgn;
      end
      if (o_ready) break;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_lat));
    check({tag, " result"}, o_result, exp);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " dbz"}, {63'd0, o_div_by_zero}, {63'd0, (b == 32'd0)});
`endif
    @(negedge i_clk);
    i_start    = 1'b0;
    i_opdata_0 = '0;
    i_opdata_1 = '0;
    @(posedge i_clk);
    #1;
    check({tag, " ready drop"}, {63'd0, o_ready}, 64'd0);
    check({tag, " result clr"}, o_result, 64'd0);
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) @(posedge i_clk);
    #1;
  endtask

  initial begin
    bit seen_ready;
    i_rst_n      = 1'b0;
    i_signed_div = 1'b0;
    i_opdata_0   = '0;
    i_opdata_1   = '0;
    i_start      = 1'b0;
    i_annul      = 1'b0;
    #22;
    check("reset ready", {63'd0, o_ready}, 64'd0);
    check("reset result", o_result, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Main function
    do_div("divu 100/7",      1'b0, 32'd100,        32'd7,          {32'd2,        32'd14},        33);
    do_div("div -7/2",        1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("div 7/-2",        1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,        32'hFFFF_FFFD}, 33);
    do_div("div -100/-7",     1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},       33);
    do_div("div min/-1",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,        32'h8000_0000}, 33);
    do_div("divu max/2",      1'b0, 32'hFFFF_FFFF,  32'd2,          {32'd1,        32'h7FFF_FFFF}, 33);
    do_div("div -1/2",        1'b1, 32'hFFFF_FFFF,  32'd2,          {32'hFFFF_FFFF, 32'd0},        33);
    do_div("divu max/max",    1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0,        32'd1},         33);
    do_div("divu 3/10",       1'b0, 32'd3,          32'd10,         {32'd3,        32'd0},         33);
    do_div("divu 2^31/3",     1'b0, 32'h8000_0000,  32'd3,          {32'd2,        32'h2AAA_AAAA}, 33);
    do_div("divu 5/0",        1'b0, 32'd5,          32'd0,          64'd0,                         2);
    do_div("div -5/0",        1'b1, 32'hFFFF_FFFB,  32'd0,          64'd0,                         2);

    // Start and annul together in FREE: annul wins, nothing starts.
    @(negedge i_clk);
    i_opdata_0 = 32'd9;
    i_opdata_1 = 32'd0;
    i_start    = 1'b1;
    i_annul    = 1'b1;
    wait_edges(3);
    check("start+annul ready", {63'd0, o_ready}, 64'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    i_annul = 1'b0;

    // Annul mid-division at cnt=10 (cnt equals edges-1 after acceptance).
    @(negedge i_clk);
    i_signed_div = 1'b0;
    i_opdata_0   = 32'd100;
    i_opdata_1   = 32'd7;
    i_start      = 1'b1;
    wait_edges(11);
    i_annul = 1'b1;
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    i_annul = 1'b0;
    seen_ready = o_ready;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1;
      if (o_ready) seen_ready = 1'b1;
    end
    check("annul no ready", {63'd0, seen_ready}, 64'd0);
    check("annul result", o_result, 64'd0);
    do_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Async reset at cnt=20.
    @(negedge i_clk);
    i_opdata_0 = 32'd100;
    i_opdata_1 = 32'd7;
    i_start    = 1'b1;
    wait_edges(21);
    i_start = 1'b0;
    #1;
    i_rst_n = 1'b0;
    #1;
    check("rst mid ready", {63'd0, o_ready}, 64'd0);
    check("rst mid result", o_result, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_div("divu 1000/10 after rst", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);

    // Async reset while a result is presented: outputs clear immediately.
    @(negedge i_clk);
    i_signed_div = 1'b0;
    i_opdata_0   = 32'd123;
    i_opdata_1   = 32'd10;
    i_start      = 1'b1;
    wait_edges(33);
    check("end ready", {63'd0, o_ready}, 64'd1);
    check("end result", o_result, {32'd3, 32'd12});
    #1;
    i_rst_n = 1'b0;
    #1;
    check("rst end ready", {63'd0, o_ready}, 64'd0);
    check("rst end result", o_result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("rst end dbz", {63'd0, o_div_by_zero}, 64'd0);
`endif
    @(negedge i_clk);
    i_start = 1'b0;
    i_rst_n = 1'b1;
    do_div("div -9/4 after rst", 1'b1, 32'hFFFF_FFF7, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
